// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int PERF_W = 16;

endpackage

// File: rtl/mem_port_arbiter_perf_cnt.sv
// Saturating event counter used for the arbiter's optional performance outputs.
module arb_perf_cnt
  import mem_arb_pkg::*;
#(
  parameter int W = PERF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Count up on inc, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the instruction
// fetch port and the load/store port. Data normally wins a conflict; after
// STARVE_MAX consecutive data wins against a waiting fetch, fetch is forced.
// Define ARB_PERF_CNT_EN to add grant/conflict performance counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall,
  output logic              grant_d
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_if_grants,
  output logic [PERF_W-1:0] perf_d_grants,
  output logic [PERF_W-1:0] perf_conflicts
`endif
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);
  localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);
  localparam logic [STV_W-1:0] STARVE_ONE = STV_W'(1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Data takes the port unless fetch is also waiting and has been starved.
  logic d_wins;
  assign d_wins = d_req & ~(if_req & (starve_q == STARVE_TOP));

  // Next-state, request latching and starvation bookkeeping.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (d_wins) begin
          owner_d = OWN_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          state_d = ACCESS;
        end else if (if_req) begin
          owner_d = OWN_IF;
          addr_d  = if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          state_d = ACCESS;
        end
        if (d_wins && if_req) begin
          if (starve_q != STARVE_TOP) begin
            starve_d = starve_q + STARVE_ONE;
          end
        end else begin
          starve_d = '0;
        end
      end
      ACCESS: begin
        lat_d   = LAT_LOAD;
        state_d = (MEM_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        lat_d = lat_q - LAT_ONE;
        if (lat_q == LAT_ONE) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      lat_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant_d   = (owner_q == OWN_D);
  assign if_ack    = (state_q == RESP) & (owner_q == OWN_IF);
  assign d_ack     = (state_q == RESP) & (owner_q == OWN_D);
  assign if_rdata  = if_ack ? mem_rdata : '0;
  assign d_rdata   = d_ack ? mem_rdata : '0;
  assign cpu_stall = reset & ((if_req & ~if_ack) | (d_req & ~d_ack));

`ifdef ARB_PERF_CNT_EN
  logic idle_c;
  assign idle_c = (state_q == IDLE);

  arb_perf_cnt #(.W(PERF_W)) u_perf_if (
    .clk   (clk),
    .reset (reset),
    .inc   (idle_c & if_req & ~d_wins),
    .cnt   (perf_if_grants)
  );

  arb_perf_cnt #(.W(PERF_W)) u_perf_d (
    .clk   (clk),
    .reset (reset),
    .inc   (idle_c & d_wins),
    .cnt   (perf_d_grants)
  );

  arb_perf_cnt #(.W(PERF_W)) u_perf_conf (
    .clk   (clk),
    .reset (reset),
    .inc   (idle_c & if_req & d_req),
    .cnt   (perf_conflicts)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small fixed-latency memory model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          cpu_stall;
  logic          grant_d;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]   perf_if_grants;
  logic [15:0]   perf_d_grants;
  logic [15:0]   perf_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cpu_stall (cpu_stall),
    .grant_d   (grant_d)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_grants (perf_if_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  // Memory model: 64 words, read data appears two cycles after mem_en.
  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] rd_s0 = '0;
  logic [DW-1:0] rd_s1 = '0;
  logic          init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[16]   <= 32'h2008_0005;
      init_done <= 1'b1;
    end else begin
      if (mem_en) begin
        if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
        rd_s0 <= mem[mem_addr[5:0]];
      end
      rd_s1 <= rd_s0;
    end
  end
  assign mem_rdata = rd_s1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  int     nack;
  int     ngrant;
  logic   order [0:5];
  logic   exp_order [0:5];

  initial begin
    exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
    exp_order[3] = 1'b1; exp_order[4] = 1'b1; exp_order[5] = 1'b0;
    for (int k = 0; k < 6; k++) order[k] = 1'b0;

    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    cyc(); cyc();
    if_req = 1'b1; d_req = 1'b1;
    #1;
    chk("rst_stall_forced", 32'(cpu_stall), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_grant_d", 32'(grant_d), 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();

    // Fetch of 0x10
    if_addr = 32'h10; if_req = 1'b1;
    #1 chk("f_stall_c0", 32'(cpu_stall), 32'd1);
    cyc();
    chk("f_mem_en_c1", 32'(mem_en), 32'd1);
    chk("f_mem_addr_c1", mem_addr, 32'h10);
    chk("f_mem_we_c1", 32'(mem_we), 32'd0);
    chk("f_stall_c1", 32'(cpu_stall), 32'd1);
    cyc();
    chk("f_mem_en_c2", 32'(mem_en), 32'd0);
    chk("f_ack_c2", 32'(if_ack), 32'd0);
    chk("f_stall_c2", 32'(cpu_stall), 32'd1);
    cyc();
    chk("f_ack_c3", 32'(if_ack), 32'd1);
    chk("f_rdata_c3", if_rdata, 32'h2008_0005);
    chk("f_stall_c3", 32'(cpu_stall), 32'd0);
    if_req = 1'b0;
    cyc();
    chk("f_ack_c4", 32'(if_ack), 32'd0);

    // Store 0xC to address 0
    d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'hC; d_req = 1'b1;
    cyc();
    chk("st_mem_en", 32'(mem_en), 32'd1);
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_wdata", mem_wdata, 32'hC);
    chk("st_grant_d", 32'(grant_d), 32'd1);
    cyc();
    chk("st_ack_c2", 32'(d_ack), 32'd0);
    cyc();
    chk("st_ack_c3", 32'(d_ack), 32'd1);
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    cyc();

    // Load back address 0
    d_req = 1'b1;
    cyc();
    chk("ld_mem_we", 32'(mem_we), 32'd0);
    cyc(); cyc();
    chk("ld_ack", 32'(d_ack), 32'd1);
    chk("ld_rdata", d_rdata, 32'hC);
    d_req = 1'b0;
    cyc();

    // Simultaneous fetch and load: data first, then fetch
    if_addr = 32'h10; if_req = 1'b1; d_addr = 32'h0; d_req = 1'b1;
    cyc();
    chk("sim_grant_c1", 32'(grant_d), 32'd1);
    chk("sim_addr_c1", mem_addr, 32'h0);
    cyc();
    cyc();
    chk("sim_d_ack_c3", 32'(d_ack), 32'd1);
    chk("sim_if_ack_c3", 32'(if_ack), 32'd0);
    chk("sim_d_rdata_c3", d_rdata, 32'hC);
    chk("sim_stall_c3", 32'(cpu_stall), 32'd1);
    d_req = 1'b0;
    cyc();
    chk("sim_stall_c4", 32'(cpu_stall), 32'd1);
    cyc();
    chk("sim_grant_c5", 32'(grant_d), 32'd0);
    chk("sim_addr_c5", mem_addr, 32'h10);
    chk("sim_mem_en_c5", 32'(mem_en), 32'd1);
    cyc();
    chk("sim_stall_c6", 32'(cpu_stall), 32'd1);
    chk("sim_if_ack_c6", 32'(if_ack), 32'd0);
    cyc();
    chk("sim_if_ack_c7", 32'(if_ack), 32'd1);
    chk("sim_if_rdata_c7", if_rdata, 32'h2008_0005);
    chk("sim_stall_c7", 32'(cpu_stall), 32'd0);
    if_req = 1'b0;
    cyc();

    // Reset during WAIT abandons the load
    d_addr = 32'h0; d_req = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rw_mem_en", 32'(mem_en), 32'd0);
    chk("rw_mem_addr", mem_addr, 32'd0);
    chk("rw_grant_d", 32'(grant_d), 32'd0);
    chk("rw_stall", 32'(cpu_stall), 32'd0);
    chk("rw_d_ack", 32'(d_ack), 32'd0);
    d_req = 1'b0;
    cyc();
    reset = 1'b1;
    nack = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (if_ack || d_ack) nack++;
    end
    chk("rw_no_ack_after", 32'(nack), 32'd0);

    // Starvation: both requests held, grant order d d if d d if
    if_addr = 32'h10; d_addr = 32'h0; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    ngrant = 0;
    for (int k = 0; k < 60 && ngrant < 6; k++) begin
      cyc();
      if (d_ack || if_ack) begin
        order[ngrant] = d_ack;
        ngrant++;
        if (ngrant == 6) begin
          if_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    chk("stv_grant_count", 32'(ngrant), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stv_order_%0d", k), 32'(order[k]), 32'(exp_order[k]));
    end
    cyc();
    chk("stv_idle_stall", 32'(cpu_stall), 32'd0);
`ifdef ARB_PERF_CNT_EN
    chk("perf_d_grants", 32'(perf_d_grants), 32'd4);
    chk("perf_if_grants", 32'(perf_if_grants), 32'd2);
    chk("perf_conflicts", 32'(perf_conflicts), 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
